// File: rtl/cpu_mem_bridge_pkg.sv
// Shared types and constants for the CPU-to-SoC memory bridge.
package cpu_mem_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    RSP  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/bus_timeout_counter.sv
// Per-phase stall timer: counts cycles without progress and flags expiry at TIMEOUT_CYCLES.
module bus_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset_,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  if (TIMEOUT_CYCLES == 0) begin : g_off
    logic unused_timer_inputs;
    assign unused_timer_inputs = clk ^ reset_ ^ clear ^ enable;
    assign expired             = 1'b0;
  end else begin : g_on
    localparam int unsigned   CW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
      count_d = count_q;
      if (clear) begin
        count_d = '0;
      end else if (enable && (count_q != LIMIT)) begin
        count_d = count_q + CW'(1);
      end
    end

    always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
        count_q <= '0;
      end else begin
        count_q <= count_d;
      end
    end

    assign expired = enable && (count_q == LIMIT);
  end

endmodule

// File: rtl/cpu_mem_bridge.sv
// Bridges the CPU's single-outstanding valid/ready port onto the split command/response
// memory bus, with a registered command stage and a per-phase timeout abort.
module cpu_mem_bridge
  import cpu_mem_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter bit          WR_RSP         = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset_,
  input  logic                    cpu_valid,
  input  logic                    cpu_instr,
  input  logic [ADDR_WIDTH-1:0]   cpu_addr,
  input  logic [DATA_WIDTH-1:0]   cpu_wdata,
  input  logic [DATA_WIDTH/8-1:0] cpu_wstrb,
  output logic                    cpu_ready,
  output logic [DATA_WIDTH-1:0]   cpu_rdata,
  output logic                    mem_cmd_valid,
  input  logic                    mem_cmd_ready,
  output logic                    mem_cmd_instr,
  output logic                    mem_cmd_wr,
  output logic [ADDR_WIDTH-1:0]   mem_cmd_addr,
  output logic [DATA_WIDTH-1:0]   mem_cmd_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_cmd_be,
  input  logic                    mem_rsp_ready,
  input  logic [DATA_WIDTH-1:0]   mem_rsp_rdata,
  output logic                    bus_err,
  output logic [ADDR_WIDTH-1:0]   err_addr,
  output logic                    err_wr
);

  localparam logic [DATA_WIDTH-1:0] ERR_WORD = DATA_WIDTH'(ERR_RDATA);

  state_e                  state_q, state_d;
  logic                    cpu_ready_q, cmd_valid_q, bus_err_q, err_wr_q;
  logic                    cmd_instr_q, cmd_wr_q;
  logic [ADDR_WIDTH-1:0]   cmd_addr_q, err_addr_q;
  logic [DATA_WIDTH-1:0]   cmd_wdata_q, rdata_q;
  logic [DATA_WIDTH/8-1:0] cmd_be_q;

  logic capture, progress, rsp_take, abort, waiting, expired;

  assign waiting = (state_q == CMD) || (state_q == RSP);

  // NOTE: every combinational output gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    progress = 1'b0;
    rsp_take = 1'b0;
    abort    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cpu_valid) begin
          capture = 1'b1;
          state_d = CMD;
        end
      end
      CMD: begin
        if (mem_cmd_ready) begin
          progress = 1'b1;
          state_d  = (cmd_wr_q && !WR_RSP) ? DONE : RSP;
        end else if (expired) begin
          abort   = 1'b1;
          state_d = DONE;
        end
      end
      RSP: begin
        // A response arriving on the expiry cycle still counts as progress.
        if (mem_rsp_ready) begin
          progress = 1'b1;
          rsp_take = 1'b1;
          state_d  = DONE;
        end else if (expired) begin
          abort   = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  bus_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset_  (reset_),
    .clear   (!waiting || progress),
    .enable  (waiting),
    .expired (expired)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      // NOTE: every register, datapath included, is reset because all outputs must read 0 in reset.
      state_q     <= IDLE;
      cpu_ready_q <= 1'b0;
      cmd_valid_q <= 1'b0;
      bus_err_q   <= 1'b0;
      cmd_instr_q <= 1'b0;
      cmd_wr_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cmd_be_q    <= '0;
      rdata_q     <= '0;
      err_addr_q  <= '0;
      err_wr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cpu_ready_q <= (state_d == DONE);
      cmd_valid_q <= (state_d == CMD);
      bus_err_q   <= abort;
      if (capture) begin
        cmd_instr_q <= cpu_instr;
        cmd_wr_q    <= |cpu_wstrb;
        cmd_addr_q  <= cpu_addr;
        cmd_wdata_q <= cpu_wdata;
        cmd_be_q    <= cpu_wstrb;
      end
      // Write responses carry no data; cpu_rdata keeps its last read value.
      if (rsp_take && !cmd_wr_q) begin
        rdata_q <= mem_rsp_rdata;
      end else if (abort && !cmd_wr_q) begin
        rdata_q <= ERR_WORD;
      end
      if (abort) begin
        err_addr_q <= cmd_addr_q;
        err_wr_q   <= cmd_wr_q;
      end
    end
  end

  assign cpu_ready     = cpu_ready_q;
  assign cpu_rdata     = rdata_q;
  assign mem_cmd_valid = cmd_valid_q;
  assign mem_cmd_instr = cmd_instr_q;
  assign mem_cmd_wr    = cmd_wr_q;
  assign mem_cmd_addr  = cmd_addr_q;
  assign mem_cmd_wdata = cmd_wdata_q;
  assign mem_cmd_be    = cmd_be_q;
  assign bus_err       = bus_err_q;
  assign err_addr      = err_addr_q;
  assign err_wr        = err_wr_q;

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Bench for cpu_mem_bridge: two instances (WR_RSP=0 and WR_RSP=1, TIMEOUT_CYCLES=8) driven
// by directed and randomized transactions and checked against a cycle-arithmetic model.
module tb_cpu_mem_bridge;

  localparam int          T   = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic reset_ = 1'b0;
  always #5 clk = ~clk;

  logic        cpu_valid_a     [2];
  logic        cpu_instr_a     [2];
  logic [31:0] cpu_addr_a      [2];
  logic [31:0] cpu_wdata_a     [2];
  logic [3:0]  cpu_wstrb_a     [2];
  logic        mem_cmd_ready_a [2];
  logic        mem_rsp_ready_a [2];
  logic [31:0] mem_rsp_rdata_a [2];

  logic        cpu_ready_a     [2];
  logic [31:0] cpu_rdata_a     [2];
  logic        mem_cmd_valid_a [2];
  logic        mem_cmd_instr_a [2];
  logic        mem_cmd_wr_a    [2];
  logic [31:0] mem_cmd_addr_a  [2];
  logic [31:0] mem_cmd_wdata_a [2];
  logic [3:0]  mem_cmd_be_a    [2];
  logic        bus_err_a       [2];
  logic [31:0] err_addr_a      [2];
  logic        err_wr_a        [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    cpu_mem_bridge #(
      .ADDR_WIDTH     (32),
      .DATA_WIDTH     (32),
      .WR_RSP         (g == 1),
      .TIMEOUT_CYCLES (T),
      .ERR_RDATA      (ERR)
    ) dut (
      .clk           (clk),
      .reset_        (reset_),
      .cpu_valid     (cpu_valid_a[g]),
      .cpu_instr     (cpu_instr_a[g]),
      .cpu_addr      (cpu_addr_a[g]),
      .cpu_wdata     (cpu_wdata_a[g]),
      .cpu_wstrb     (cpu_wstrb_a[g]),
      .cpu_ready     (cpu_ready_a[g]),
      .cpu_rdata     (cpu_rdata_a[g]),
      .mem_cmd_valid (mem_cmd_valid_a[g]),
      .mem_cmd_ready (mem_cmd_ready_a[g]),
      .mem_cmd_instr (mem_cmd_instr_a[g]),
      .mem_cmd_wr    (mem_cmd_wr_a[g]),
      .mem_cmd_addr  (mem_cmd_addr_a[g]),
      .mem_cmd_wdata (mem_cmd_wdata_a[g]),
      .mem_cmd_be    (mem_cmd_be_a[g]),
      .mem_rsp_ready (mem_rsp_ready_a[g]),
      .mem_rsp_rdata (mem_rsp_rdata_a[g]),
      .bus_err       (bus_err_a[g]),
      .err_addr      (err_addr_a[g]),
      .err_wr        (err_wr_a[g])
    );
  end

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: what each instance should be holding on its sticky outputs.
  logic [31:0] exp_rdata    [2];
  logic [31:0] exp_err_addr [2];
  logic        exp_err_wr   [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      exp_rdata[i]    = '0;
      exp_err_addr[i] = '0;
      exp_err_wr[i]   = 1'b0;
    end
  endtask

  function automatic logic [139:0] all_outputs(input int d);
    return {cpu_ready_a[d], cpu_rdata_a[d], mem_cmd_valid_a[d], mem_cmd_instr_a[d],
            mem_cmd_wr_a[d], mem_cmd_addr_a[d], mem_cmd_wdata_a[d], mem_cmd_be_a[d],
            bus_err_a[d], err_addr_a[d], err_wr_a[d]};
  endfunction

  // One CPU access on instance d. Stall counts are cycles the bus holds off before the
  // ready pulse; a stall above T means the pulse arrives only after the abort.
  task automatic run_txn(input int d, input logic instr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb,
                         input int cmd_stall, input int rsp_stall,
                         input logic [31:0] rsp_data, input string tag);
    bit          wr        = |wstrb;
    bit          rsp_phase = !wr || (d == 1);
    int          a         = 1 + cmd_stall;
    int          r         = -1;
    int          d_exp;
    int          cmd_end;
    bit          abort     = 1'b0;
    int          last;
    int          first_ready = -1;
    int          n_ready   = 0;
    int          n_pulse   = 0;
    int          err_at    = -1;
    bit          cmd_bad   = 1'b0;
    bit          fld_bad   = 1'b0;
    logic [31:0] rdata_at  = 'x;

    if (cmd_stall > T) begin
      abort   = 1'b1;
      cmd_end = T + 1;
      d_exp   = T + 2;
    end else begin
      cmd_end = a;
      if (!rsp_phase) begin
        d_exp = a + 1;
      end else begin
        r = a + 1 + rsp_stall;
        if (rsp_stall > T) begin
          abort = 1'b1;
          d_exp = a + T + 2;
        end else begin
          d_exp = r + 1;
        end
      end
    end

    if (abort) begin
      exp_err_addr[d] = addr;
      exp_err_wr[d]   = wr;
      if (!wr) exp_rdata[d] = ERR;
    end else if (!wr) begin
      exp_rdata[d] = rsp_data;
    end

    last = d_exp;
    if (a > last) last = a;
    if (r > last) last = r;
    last = last + 2;

    @(posedge clk); #1;
    cpu_valid_a[d] = 1'b1;
    cpu_instr_a[d] = instr;
    cpu_addr_a[d]  = addr;
    cpu_wdata_a[d] = wdata;
    cpu_wstrb_a[d] = wstrb;

    for (int c = 1; c <= last; c++) begin
      @(posedge clk); #1;
      mem_cmd_ready_a[d] = (c == a);
      mem_rsp_ready_a[d] = (c == r);
      mem_rsp_rdata_a[d] = (c == r) ? rsp_data : $urandom;
      if (first_ready >= 0 && c == first_ready + 1) cpu_valid_a[d] = 1'b0;
      @(negedge clk);
      if (cpu_ready_a[d] === 1'b1) begin
        n_ready++;
        if (first_ready < 0) begin
          first_ready = c;
          rdata_at    = cpu_rdata_a[d];
        end
      end
      if (bus_err_a[d] === 1'b1) begin
        n_pulse++;
        err_at = c;
      end
      if (mem_cmd_valid_a[d] !== (c <= cmd_end)) cmd_bad = 1'b1;
      if (c <= cmd_end &&
          {mem_cmd_instr_a[d], mem_cmd_wr_a[d], mem_cmd_addr_a[d], mem_cmd_wdata_a[d], mem_cmd_be_a[d]}
          !== {instr, wr, addr, wdata, wstrb}) fld_bad = 1'b1;
    end
    cpu_valid_a[d]     = 1'b0;
    mem_cmd_ready_a[d] = 1'b0;
    mem_rsp_ready_a[d] = 1'b0;

    n_cmp++;
    if (first_ready != d_exp) begin
      n_err++;
      $display("FAIL %s latency: cpu_ready at cycle %0d, expected cycle %0d", tag, first_ready, d_exp);
    end
    n_cmp++;
    if (n_ready != 1) begin
      n_err++;
      $display("FAIL %s ready_pulses: %0d cycles high, expected 1", tag, n_ready);
    end
    n_cmp++;
    if (n_pulse != (abort ? 1 : 0) || err_at != (abort ? d_exp : -1)) begin
      n_err++;
      $display("FAIL %s bus_err: %0d pulses last at %0d, expected %0d at %0d",
               tag, n_pulse, err_at, abort ? 1 : 0, abort ? d_exp : -1);
    end
    n_cmp++;
    if (rdata_at !== exp_rdata[d]) begin
      n_err++;
      $display("FAIL %s rdata: got %h expected %h", tag, rdata_at, exp_rdata[d]);
    end
    n_cmp++;
    if (cmd_bad) begin
      n_err++;
      $display("FAIL %s cmd_valid_window: asserted outside cycles 1..%0d or missing, expected exactly that window", tag, cmd_end);
    end
    n_cmp++;
    if (fld_bad) begin
      n_err++;
      $display("FAIL %s cmd_fields: got addr %h be %b, expected stable addr %h be %b",
               tag, mem_cmd_addr_a[d], mem_cmd_be_a[d], addr, wstrb);
    end
    n_cmp++;
    if ({err_addr_a[d], err_wr_a[d]} !== {exp_err_addr[d], exp_err_wr[d]}) begin
      n_err++;
      $display("FAIL %s err_log: got %h/%b expected %h/%b",
               tag, err_addr_a[d], err_wr_a[d], exp_err_addr[d], exp_err_wr[d]);
    end
    n_cmp++;
    if (cpu_rdata_a[d] !== exp_rdata[d]) begin
      n_err++;
      $display("FAIL %s rdata_hold: got %h expected %h", tag, cpu_rdata_a[d], exp_rdata[d]);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cpu_valid_a[i] = 1'b0; cpu_instr_a[i] = 1'b0; cpu_addr_a[i] = '0;
      cpu_wdata_a[i] = '0;   cpu_wstrb_a[i] = '0;   mem_cmd_ready_a[i] = 1'b0;
      mem_rsp_ready_a[i] = 1'b0; mem_rsp_rdata_a[i] = '0;
    end
    model_reset();
    reset_ = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (all_outputs(i) !== '0) begin
        n_err++;
        $display("FAIL reset_state[%0d]: outputs %h, expected all zero", i, all_outputs(i));
      end
    end
    reset_ = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read_basic();
    run_txn(0, 1'b0, 32'h0000_0100, 32'h0, 4'b0000, 0, 0, 32'h1234_5678, "read_basic");
    run_txn(1, 1'b1, 32'h0000_0104, 32'h0, 4'b0000, 0, 0, 32'hCAFE_0001, "ifetch_basic");
  endtask

  task automatic test_write_stall();
    run_txn(0, 1'b0, 32'h0000_0200, 32'hA5A5_5A5A, 4'b0011, 5, 0, 32'h0, "write_stall");
  endtask

  task automatic test_wr_rsp();
    @(posedge clk); #1;
    mem_rsp_ready_a[1] = 1'b1;
    mem_rsp_rdata_a[1] = 32'h5555_AAAA;
    @(negedge clk);
    @(posedge clk); #1;
    mem_rsp_ready_a[1] = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({cpu_ready_a[1], mem_cmd_valid_a[1], cpu_rdata_a[1]} !== {1'b0, 1'b0, exp_rdata[1]}) begin
      n_err++;
      $display("FAIL stray_rsp_idle: ready %b cmd_valid %b rdata %h, expected 0 0 %h",
               cpu_ready_a[1], mem_cmd_valid_a[1], cpu_rdata_a[1], exp_rdata[1]);
    end
    run_txn(1, 1'b0, 32'h0000_0300, 32'h0BAD_F00D, 4'b1111, 1, 3, 32'h7777_7777, "write_rsp");
  endtask

  task automatic test_timeout();
    run_txn(0, 1'b0, 32'h0000_2000, 32'h0, 4'b0000, 0, 20, 32'h1111_2222, "rsp_timeout");
    run_txn(1, 1'b0, 32'h0000_3000, 32'h1234_0000, 4'b1000, 12, 0, 32'h0, "cmd_timeout_wr");
    run_txn(1, 1'b0, 32'h0000_3004, 32'h0, 4'b1100, 0, 12, 32'h0, "rsp_timeout_wr");
  endtask

  task automatic test_expiry_coincide();
    run_txn(0, 1'b0, 32'h0000_4000, 32'h0, 4'b0000, 0, T, 32'h600D_DA7A, "rsp_at_expiry");
    run_txn(0, 1'b0, 32'h0000_4004, 32'h9, 4'b0001, T, 0, 32'h0, "cmd_at_expiry");
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    cpu_valid_a[0] = 1'b1;
    cpu_addr_a[0]  = 32'h0000_5000;
    cpu_wstrb_a[0] = 4'b0000;
    @(posedge clk); #1;
    mem_cmd_ready_a[0] = 1'b1;
    @(posedge clk); #1;
    mem_cmd_ready_a[0] = 1'b0;
    #3;
    reset_ = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (all_outputs(i) !== '0) begin
        n_err++;
        $display("FAIL reset_async[%0d]: outputs %h, expected all zero", i, all_outputs(i));
      end
    end
    cpu_valid_a[0] = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_ = 1'b1;
    @(negedge clk);
    run_txn(0, 1'b0, 32'h0000_5004, 32'h0, 4'b0000, 1, 2, 32'hFEED_BEEF, "after_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      int          d     = $urandom_range(0, 1);
      bit          rd    = ($urandom_range(0, 1) == 0);
      logic [3:0]  wstrb = rd ? 4'b0000 : 4'($urandom_range(1, 15));
      logic [31:0] addr  = $urandom;
      logic [31:0] wdata = $urandom;
      logic [31:0] rdata = $urandom;
      run_txn(d, 1'($urandom_range(0, 1)), addr, wdata, wstrb,
              $urandom_range(0, 10), $urandom_range(0, 10), rdata, $sformatf("random%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_stall();
    test_wr_rsp();
    test_timeout();
    test_expiry_coincide();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
